// File: rtl/sprite_render_pipe.sv
// sprite_render_pipe: three-stage single-sprite renderer between the VGA
// timing generator and the colour output. Handles directional walk animation
// (updated only at frame start) and a per-frame sprite/wall collision flag.
// Optional build macro: COLLISION_HITBOX_EN shrinks the collision area by
// HB_INSET pixels on every side; rendering is unaffected by it.
module sprite_render_pipe #(
  parameter int SPR_W       = 32,
  parameter int SPR_H       = 32,
  parameter int ANIM_FRAMES = 2,
  parameter int ANIM_DIV    = 8,
  parameter int HB_INSET    = 4,
  localparam int AF_W   = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1,
  localparam int ADDR_W = 2 + $clog2(ANIM_FRAMES) + $clog2(SPR_H) + $clog2(SPR_W)
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic              blank,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic [7:0]        keycode,
  output logic [ADDR_W-1:0] spr_addr,
  input  logic [11:0]       spr_rgb,
  input  logic              spr_opaque,
  input  logic [11:0]       bg_rgb,
  input  logic              bg_solid,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              collision,
  output logic [1:0]        dir,
  output logic [AF_W-1:0]   anim_frame
);

  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  // stage 0 combinational terms
  logic [9:0] lx;
  logic [9:0] ly;
  logic       in_box0;
  logic       fs0;
  logic       hb0;
  logic       moving;
  logic [1:0] key_dir;
  logic       hit2;

  // stage 1
  logic [ADDR_W-1:0] spr_addr_q, spr_addr_d;
  logic              in_box1_q, in_box1_d;
  logic              vis1_q, vis1_d;
  logic              fs1_q, fs1_d;
  logic              hb1_q, hb1_d;

  // stage 2
  logic              in_box2_q, in_box2_d;
  logic              vis2_q, vis2_d;
  logic              fs2_q, fs2_d;
  logic              hb2_q, hb2_d;

  // output and frame state
  logic [11:0]       rgb_q, rgb_d;
  logic              hit_acc_q, hit_acc_d;
  logic              collision_q, collision_d;
  logic [1:0]        dir_q, dir_d;
  logic [AF_W-1:0]   anim_q, anim_d;
  logic [DIV_W-1:0]  div_q, div_d;

  // next-state logic for every pipeline stage and the frame-level state
  always_comb begin
    lx      = draw_x - sprite_x;
    ly      = draw_y - sprite_y;
    in_box0 = (32'(lx) < SPR_W) && (32'(ly) < SPR_H);
    fs0     = (draw_x == 10'd0) && (draw_y == 10'd0);

`ifdef COLLISION_HITBOX_EN
    hb0 = (32'(lx) >= HB_INSET) && (32'(lx) < SPR_W - HB_INSET) &&
          (32'(ly) >= HB_INSET) && (32'(ly) < SPR_H - HB_INSET);
`else
    // Whole sprite box may collide; the inset is non-negative so this is true.
    hb0 = (HB_INSET >= 0);
`endif

    moving  = 1'b1;
    key_dir = dir_q;
    case (keycode)
      8'h07:   key_dir = 2'd0;
      8'h1A:   key_dir = 2'd1;
      8'h04:   key_dir = 2'd2;
      8'h16:   key_dir = 2'd3;
      default: moving  = 1'b0;
    endcase

    dir_d  = dir_q;
    anim_d = anim_q;
    div_d  = div_q;
    if (fs0) begin
      if (moving) begin
        dir_d = key_dir;
        if (div_q == DIV_W'(ANIM_DIV - 1)) begin
          div_d  = '0;
          anim_d = (ANIM_FRAMES > 1) ? anim_q + AF_W'(1) : '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end else begin
        div_d  = '0;
        anim_d = '0;
      end
    end

    // Address uses the post-update pose so pixel (0,0) matches the rest of the frame.
    spr_addr_d = '0;
    if (in_box0) begin
      spr_addr_d = ((ADDR_W'(dir_d) * ADDR_W'(ANIM_FRAMES) + ADDR_W'(anim_d))
                    * ADDR_W'(SPR_H) + ADDR_W'(ly)) * ADDR_W'(SPR_W) + ADDR_W'(lx);
    end
    in_box1_d = in_box0;
    vis1_d    = blank;
    fs1_d     = fs0;
    hb1_d     = hb0;

    in_box2_d = in_box1_q;
    vis2_d    = vis1_q;
    fs2_d     = fs1_q;
    hb2_d     = hb1_q;

    rgb_d = 12'h000;
    if (vis2_q) begin
      rgb_d = (in_box2_q && spr_opaque) ? spr_rgb : bg_rgb;
    end

    // The frame-start pixel's own hit seeds the new frame's accumulator.
    hit2        = vis2_q && in_box2_q && spr_opaque && bg_solid && hb2_q;
    collision_d = collision_q;
    hit_acc_d   = hit_acc_q | hit2;
    if (fs2_q) begin
      collision_d = hit_acc_q;
      hit_acc_d   = hit2;
    end
  end

  // all state registers with asynchronous clear
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      spr_addr_q  <= '0;
      in_box1_q   <= 1'b0;
      vis1_q      <= 1'b0;
      fs1_q       <= 1'b0;
      hb1_q       <= 1'b0;
      in_box2_q   <= 1'b0;
      vis2_q      <= 1'b0;
      fs2_q       <= 1'b0;
      hb2_q       <= 1'b0;
      rgb_q       <= 12'h000;
      hit_acc_q   <= 1'b0;
      collision_q <= 1'b0;
      dir_q       <= 2'd2;
      anim_q      <= '0;
      div_q       <= '0;
    end else begin
      spr_addr_q  <= spr_addr_d;
      in_box1_q   <= in_box1_d;
      vis1_q      <= vis1_d;
      fs1_q       <= fs1_d;
      hb1_q       <= hb1_d;
      in_box2_q   <= in_box2_d;
      vis2_q      <= vis2_d;
      fs2_q       <= fs2_d;
      hb2_q       <= hb2_d;
      rgb_q       <= rgb_d;
      hit_acc_q   <= hit_acc_d;
      collision_q <= collision_d;
      dir_q       <= dir_d;
      anim_q      <= anim_d;
      div_q       <= div_d;
    end
  end

  assign spr_addr   = spr_addr_q;
  assign red        = rgb_q[11:8];
  assign green      = rgb_q[7:4];
  assign blue       = rgb_q[3:0];
  assign collision  = collision_q;
  assign dir        = dir_q;
  assign anim_frame = anim_q;

endmodule

// File: tb/tb_sprite_render_pipe.sv
// Directed bench for sprite_render_pipe with default parameters
// (32x32 sprite, 2 walk frames, divider 8, inset 4).
module tb_sprite_render_pipe;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [9:0]  draw_x, draw_y, sprite_x, sprite_y;
  logic        blank;
  logic [7:0]  keycode;
  logic [12:0] spr_addr;
  logic [11:0] spr_rgb, bg_rgb;
  logic        spr_opaque, bg_solid;
  logic [3:0]  red, green, blue;
  logic        collision;
  logic [1:0]  dir;
  logic [0:0]  anim_frame;

  int n_checks = 0;
  int n_fail   = 0;

  sprite_render_pipe dut (
    .vga_clk(vga_clk), .reset(reset),
    .draw_x(draw_x), .draw_y(draw_y), .blank(blank),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .keycode(keycode),
    .spr_addr(spr_addr), .spr_rgb(spr_rgb), .spr_opaque(spr_opaque),
    .bg_rgb(bg_rgb), .bg_solid(bg_solid),
    .red(red), .green(green), .blue(blue),
    .collision(collision), .dir(dir), .anim_frame(anim_frame)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    int dx; int dy; int sx; int sy; int blk;
    int srgb; int sop; int bgc;
    int exp_addr; int exp_rgb;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic frame_start();
    draw_x = 10'd0; draw_y = 10'd0; step();
    draw_x = 10'd600; draw_y = 10'd400; step(); step(); step();
  endtask

  task automatic pixel(input int x, input int y);
    draw_x = 10'(x); draw_y = 10'(y); step();
    draw_x = 10'd600; draw_y = 10'd400; step(); step(); step();
  endtask

  initial begin
    logic exp_hb;
`ifdef COLLISION_HITBOX_EN
    exp_hb = 1'b0;
`else
    exp_hb = 1'b1;
`endif

    // dx, dy, sx, sy, blank, spr_rgb, opaque, bg_rgb, addr, rgb  (dir 2, frame 0 -> base 4096)
    vecs[0]  = '{100, 50, 100, 50, 1, 'hABC, 1, 'h123, 4096, 'hABC};
    vecs[1]  = '{ 99, 50, 100, 50, 1, 'hABC, 1, 'h123,    0, 'h123};
    vecs[2]  = '{ 99, 50, 100, 50, 0, 'hABC, 1, 'h123,    0, 'h000};
    vecs[3]  = '{131, 81, 100, 50, 1, 'h5A5, 1, 'h123, 5119, 'h5A5};
    vecs[4]  = '{132, 50, 100, 50, 1, 'h5A5, 1, 'h0F0,    0, 'h0F0};
    vecs[5]  = '{100, 82, 100, 50, 1, 'h5A5, 1, 'h00F,    0, 'h00F};
    vecs[6]  = '{105, 53, 100, 50, 1, 'h5A5, 0, 'h321, 4197, 'h321};
    vecs[7]  = '{110, 60, 100, 50, 0, 'h5A5, 1, 'h321, 4426, 'h000};
    vecs[8]  = '{639,479, 620,470, 1, 'hFED, 1, 'h321, 4403, 'hFED};
    vecs[9]  = '{  5, 10,1010,  5, 1, 'h777, 1, 'h321, 4275, 'h777};
    vecs[10] = '{100, 49, 100, 50, 1, 'h777, 1, 'h456,    0, 'h456};

    reset = 1'b1; blank = 1'b1; keycode = 8'h00;
    draw_x = 10'd600; draw_y = 10'd400; sprite_x = 10'd100; sprite_y = 10'd50;
    spr_rgb = 12'h000; spr_opaque = 1'b0; bg_rgb = 12'h000; bg_solid = 1'b0;
    #2;
    chk("rst_rgb", {red, green, blue}, 12'h000);
    chk("rst_coll", collision, 1'b0);
    chk("rst_dir", dir, 2'd2);
    chk("rst_anim", anim_frame, 1'b0);
    chk("rst_addr", spr_addr, 13'd0);
    step(); step();
    reset = 1'b0;
    step();

    // table of isolated pixels, each held until it leaves the pipeline
    for (int i = 0; i < 11; i++) begin
      draw_x = 10'(vecs[i].dx); draw_y = 10'(vecs[i].dy);
      sprite_x = 10'(vecs[i].sx); sprite_y = 10'(vecs[i].sy);
      blank = 1'(vecs[i].blk); spr_rgb = 12'(vecs[i].srgb);
      spr_opaque = 1'(vecs[i].sop); bg_rgb = 12'(vecs[i].bgc);
      step(); step(); step();
      chk($sformatf("vec%0d_addr", i), spr_addr, 32'(vecs[i].exp_addr));
      chk($sformatf("vec%0d_rgb", i), {red, green, blue}, 32'(vecs[i].exp_rgb));
    end

    // latency: steady background, then one sprite pixel
    sprite_x = 10'd100; sprite_y = 10'd50; blank = 1'b1;
    draw_x = 10'd99; draw_y = 10'd50; spr_rgb = 12'hABC; spr_opaque = 1'b1; bg_rgb = 12'h123;
    step(); step(); step();
    draw_x = 10'd100;
    step();
    chk("lat_addr_t1", spr_addr, 13'd4096);
    chk("lat_rgb_t1", {red, green, blue}, 12'h123);
    step();
    chk("lat_rgb_t2", {red, green, blue}, 12'h123);
    step();
    chk("lat_rgb_t3", {red, green, blue}, 12'hABC);

    // walk animation: 16 frames of right-arrow
    keycode = 8'h07;
    for (int f = 1; f <= 16; f++) begin
      frame_start();
      chk($sformatf("walk_dir_f%0d", f), dir, 2'd0);
      chk($sformatf("walk_anim_f%0d", f), anim_frame, 32'((f / 8) % 2));
      if (f == 8) begin
        draw_x = 10'd100; draw_y = 10'd50; step();
        chk("walk_addr_f8", spr_addr, 13'd1024);
      end
    end
    keycode = 8'h00;
    frame_start();
    chk("stop_anim", anim_frame, 1'b0);
    chk("stop_dir", dir, 2'd0);

    // collision: opaque sprite over solid wall whenever in box
    sprite_x = 10'd100; sprite_y = 10'd50; spr_opaque = 1'b1; bg_solid = 1'b1;
    frame_start();
    chk("coll_idle", collision, 1'b0);
    pixel(110, 60);
    chk("coll_frame_n", collision, 1'b0);
    frame_start();
    chk("coll_frame_n1", collision, 1'b1);
    step(); step(); step(); step(); step();
    chk("coll_hold", collision, 1'b1);
    frame_start();
    chk("coll_frame_n2", collision, 1'b0);
    pixel(102, 60);
    chk("coll_edge_same", collision, 1'b0);
    frame_start();
    chk("coll_hitbox_edge", collision, exp_hb);
    frame_start();
    chk("coll_edge_clear", collision, 1'b0);
    sprite_x = 10'd1020; sprite_y = 10'd1020;
    frame_start();
    chk("coll_origin_same", collision, 1'b0);
    sprite_x = 10'd100; sprite_y = 10'd50;
    frame_start();
    chk("coll_origin_next", collision, 1'b1);
    frame_start();
    chk("coll_origin_clear", collision, 1'b0);

    // turning while walking keeps the walk frame
    bg_solid = 1'b0; keycode = 8'h07;
    repeat (8) frame_start();
    chk("turn_pre_anim", anim_frame, 1'b1);
    keycode = 8'h16;
    frame_start();
    chk("turn_dir", dir, 2'd3);
    chk("turn_anim", anim_frame, 1'b1);
    draw_x = 10'd100; draw_y = 10'd50; step();
    chk("turn_addr", spr_addr, 13'd7168);
    bg_solid = 1'b1;
    pixel(110, 60);
    bg_solid = 1'b0;
    frame_start();
    chk("pre_rst_coll", collision, 1'b1);
    draw_x = 10'd110; draw_y = 10'd60; spr_rgb = 12'hABC; spr_opaque = 1'b1;
    step(); step(); step();
    chk("pre_rst_rgb", {red, green, blue}, 12'hABC);

    // asynchronous reset mid-cycle, then refill
    #2 reset = 1'b1;
    #1;
    chk("arst_rgb", {red, green, blue}, 12'h000);
    chk("arst_coll", collision, 1'b0);
    chk("arst_dir", dir, 2'd2);
    chk("arst_anim", anim_frame, 1'b0);
    chk("arst_addr", spr_addr, 13'd0);
    draw_x = 10'd600; draw_y = 10'd400; bg_rgb = 12'h123; blank = 1'b1; keycode = 8'h00;
    step();
    #3 reset = 1'b0;
    step();
    chk("refill_c1", {red, green, blue}, 12'h000);
    step();
    chk("refill_c2", {red, green, blue}, 12'h000);
    step();
    chk("refill_c3", {red, green, blue}, 12'h123);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
